id_ex_skid: RTL and testbench
=============================

Name: id_ex_skid

Overview:
- Parametrised decode-to-execute pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the fixed-width, always-advancing decode/execute register.
- Execute can back-pressure without decode losing an instruction, and a flush discards in-flight work.
- Sits between the decode and execute stages of the CPU pipeline. Provides saturating stall and bubble counters for performance analysis.

Parameters:
- DATA_W, 32, width of operand buses reg1/reg2
- ALUOP_W, 8, width of ALU operation code
- ALUSEL_W, 3, width of ALU result-select code
- REGADDR_W, 5, width of destination register address
- NOP_ALUOP, 0, aluop value driven when no valid instruction
- NOP_ALUSEL, 0, alusel value driven when no valid instruction
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all held entries
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  block can accept an instruction this cycle
- id_aluop  in  ALUOP_W  ALU operation
- id_alusel  in  ALUSEL_W  ALU result select
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wd  in  REGADDR_W  destination register address
- id_wreg  in  1  destination write enable
- ex_valid  out  1  instruction held for execute
- ex_ready  in  1  execute accepts this cycle
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  out  same widths as id_*  registered instruction fields
- stall_cnt  out  CNT_W  cycles with ex_valid=1 and ex_ready=0, saturating
- bubble_cnt  out  CNT_W  cycles with ex_valid=0, saturating

Behaviour:
- Storage is a main register (drives ex_*) and a skid register, each with a valid bit.
- id_ready = !skid_valid & !rst & !flush. This is the only combinational path.
- Transfer-in (IN) = id_valid & id_ready. Transfer-out (OUT) = ex_valid & ex_ready.
- States and transitions, evaluated on each rising edge:
  - EMPTY (main invalid): IN -> FULL, main <= id_*. Otherwise stay.
  - FULL (main valid, skid empty):
    - IN & OUT -> FULL, main <= id_*.
    - IN & !OUT -> SKID, skid <= id_*.
    - !IN & OUT -> EMPTY.
    - Neither -> hold.
  - SKID (both valid): id_ready=0. OUT -> FULL, main <= skid. Otherwise hold.
- Latency is 1 cycle: an instruction accepted at edge N appears on ex_* with ex_valid=1 after edge N. Sustained throughput is 1 per cycle when ex_ready stays high.
- Ordering is strictly FIFO. The skid entry is never overtaken.
- ex_* fields are stable while ex_valid=1 and ex_ready=0.
- Whenever ex_valid=0, outputs are forced to NOP: ex_aluop=NOP_ALUOP, ex_alusel=NOP_ALUSEL, ex_reg1=ex_reg2=0, ex_wd=0, ex_wreg=0.
- Flush has priority over all transfers:
  - After the edge, main and skid are invalid and outputs are NOP.
  - An instruction presented during the flush cycle is not accepted, since id_ready=0.
  - Counters are unaffected.
- Reset has priority over flush:
  - All valids cleared, outputs NOP, both counters 0.
  - id_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
  - Reset mid-stall drops both entries.
- Counters:
  - stall_cnt increments on each cycle with ex_valid & !ex_ready.
  - bubble_cnt increments on each cycle with !ex_valid, including the flush cycle if main was already invalid.
  - Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset, then id_valid=1 with aluop=0x21, reg1=5, reg2=7, wd=3, wreg=1, ex_ready=1 -> next cycle ex_valid=1 with the same fields. Three back-to-back instructions emerge on consecutive cycles in order. stall_cnt=0.
- Hold ex_ready=0 and send instructions A, B, C -> A on ex_*, B in skid, id_ready=0 after B, C held by decode. Release ex_ready -> A, B, C emerge in order with no loss or duplication. stall_cnt = number of stalled cycles.
- State SKID, assert flush for 1 cycle with id_valid=1 (instruction D) -> next cycle ex_valid=0, ex_aluop=NOP_ALUOP, ex_wreg=0, id_ready=1. D is never issued.
- Idle with no id_valid for 10 cycles after reset -> bubble_cnt=10, outputs NOP throughout.
- CNT_W=3, hold ex_ready=0 for 12 cycles with main valid -> stall_cnt reaches 7 and holds at 7.
- Assert rst while in state SKID -> next cycle both counters 0, ex_valid=0. id_ready=0 during rst, 1 the first cycle after rst deasserts.

Source files
------------

// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline register with a valid/ready handshake and a
// 2-entry skid buffer. Execute can stall without decode losing an
// instruction, and flush discards everything in flight. The block also keeps
// saturating stall and bubble counters for performance analysis.
module id_ex_skid #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          ALUOP_W    = 8,
    parameter int unsigned          ALUSEL_W   = 3,
    parameter int unsigned          REGADDR_W  = 5,
    parameter logic [ALUOP_W-1:0]   NOP_ALUOP  = '0,
    parameter logic [ALUSEL_W-1:0]  NOP_ALUSEL = '0,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [ALUOP_W-1:0]    id_aluop,
    input  logic [ALUSEL_W-1:0]   id_alusel,
    input  logic [DATA_W-1:0]     id_reg1,
    input  logic [DATA_W-1:0]     id_reg2,
    input  logic [REGADDR_W-1:0]  id_wd,
    input  logic                  id_wreg,

    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [ALUSEL_W-1:0]   ex_alusel,
    output logic [DATA_W-1:0]     ex_reg1,
    output logic [DATA_W-1:0]     ex_reg2,
    output logic [REGADDR_W-1:0]  ex_wd,
    output logic                  ex_wreg,

    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int unsigned INSN_W = ALUOP_W + ALUSEL_W + 2 * DATA_W + REGADDR_W + 1;

    // Occupancy: EMPTY = nothing held, FULL = main only, SKID = main + skid.
    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SKID
    } state_t;

    state_t              state;
    logic [INSN_W-1:0]   main_insn;
    logic [INSN_W-1:0]   skid_insn;
    logic [INSN_W-1:0]   id_insn;
    logic [INSN_W-1:0]   nop_insn;
    logic                in_xfer;
    logic                out_xfer;

    // Instruction fields packed into one word so storage moves as a unit.
    assign id_insn  = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
    assign nop_insn = {NOP_ALUOP, NOP_ALUSEL, {DATA_W{1'b0}}, {DATA_W{1'b0}},
                       {REGADDR_W{1'b0}}, 1'b0};

    // Only combinational path: accept whenever the skid slot is free.
    assign id_ready = (state != S_SKID) && !rst && !flush;
    assign ex_valid = (state != S_EMPTY);
    assign in_xfer  = id_valid && id_ready;
    assign out_xfer = ex_valid && ex_ready;

    // Main is reloaded with NOP whenever it empties, so ex_* come straight
    // from a register and still read as NOP while ex_valid is low.
    assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = main_insn;

    // Occupancy FSM and data movement; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            main_insn <= nop_insn;
            skid_insn <= nop_insn;
        end else if (flush) begin
            state     <= S_EMPTY;
            main_insn <= nop_insn;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state     <= S_FULL;
                        main_insn <= id_insn;
                    end
                end
                S_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_insn <= id_insn;
                    end else if (in_xfer) begin
                        state     <= S_SKID;
                        skid_insn <= id_insn;
                    end else if (out_xfer) begin
                        state     <= S_EMPTY;
                        main_insn <= nop_insn;
                    end
                end
                S_SKID: begin
                    if (out_xfer) begin
                        state     <= S_FULL;
                        main_insn <= skid_insn;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    main_insn <= nop_insn;
                end
            endcase
        end
    end

    // Saturating count of cycles where execute holds off a valid instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (ex_valid && !ex_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating count of cycles with nothing presented to execute.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!ex_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed testbench for id_ex_skid: pass-through, back-pressure with skid,
// flush, idle bubbles, counter saturation (CNT_W=3 instance) and reset.
module tb_id_ex_skid;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, ex_ready;
    logic        id_ready, ex_valid;
    logic [7:0]  id_aluop, ex_aluop;
    logic [2:0]  id_alusel, ex_alusel;
    logic [31:0] id_reg1, id_reg2, ex_reg1, ex_reg2;
    logic [4:0]  id_wd, ex_wd;
    logic        id_wreg, ex_wreg;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        id_ready3, ex_valid3;
    logic [7:0]  ex_aluop3;
    logic [2:0]  ex_alusel3;
    logic [31:0] ex_reg1_3, ex_reg2_3;
    logic [4:0]  ex_wd3;
    logic        ex_wreg3;
    logic [2:0]  stall_cnt3, bubble_cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
        .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    id_ex_skid #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready3),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_valid(ex_valid3), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop3), .ex_alusel(ex_alusel3), .ex_reg1(ex_reg1_3),
        .ex_reg2(ex_reg2_3), .ex_wd(ex_wd3), .ex_wreg(ex_wreg3),
        .stall_cnt(stall_cnt3), .bubble_cnt(bubble_cnt3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction whose fields all derive from one tag byte.
    task automatic present(input logic [7:0] t);
        id_valid  = 1'b1;
        id_aluop  = t;
        id_alusel = t[2:0];
        id_reg1   = {24'h0, t} + 32'd1000;
        id_reg2   = {24'h0, t} + 32'd2000;
        id_wd     = t[4:0];
        id_wreg   = 1'b1;
    endtask

    task automatic idle_in();
        id_valid = 1'b0;
    endtask

    // Compare every ex_* field against the instruction built from tag t.
    task automatic expect_ex(input string tag, input logic [7:0] t);
        logic [31:0] r1, r2;
        r1 = {24'h0, t} + 32'd1000;
        r2 = {24'h0, t} + 32'd2000;
        check({tag, "_valid"}, ex_valid, 1);
        check({tag, "_aluop"}, ex_aluop, t);
        check({tag, "_alusel"}, ex_alusel, t[2:0]);
        check({tag, "_reg1"}, ex_reg1, r1);
        check({tag, "_reg2"}, ex_reg2, r2);
        check({tag, "_wd"}, ex_wd, t[4:0]);
        check({tag, "_wreg"}, ex_wreg, 1);
    endtask

    task automatic expect_nop(input string tag);
        check({tag, "_valid"}, ex_valid, 0);
        check({tag, "_nop"}, {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        id_valid = 1'b0; id_aluop = '0; id_alusel = '0;
        id_reg1 = '0; id_reg2 = '0; id_wd = '0; id_wreg = 1'b0;
        #2;
        step(); step();

        // Reset state
        check("rst_id_ready", id_ready, 0);
        expect_nop("rst");
        check("rst_stall", stall_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", id_ready, 1);

        // Idle for 10 cycles: each one is a bubble, outputs stay NOP
        for (int i = 0; i < 10; i++) begin
            step();
            expect_nop("idle");
        end
        check("idle_bubble", bubble_cnt, 10);

        // Spec example instruction and back-to-back flow at full rate
        ex_ready = 1'b1;
        id_valid = 1'b1; id_aluop = 8'h21; id_alusel = 3'd0;
        id_reg1 = 32'd5; id_reg2 = 32'd7; id_wd = 5'd3; id_wreg = 1'b1;
        step();
        check("ex1_valid", ex_valid, 1);
        check("ex1_fields", {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg},
              {8'h21, 3'd0, 32'd5, 32'd7, 5'd3, 1'b1});
        present(8'h11); step(); expect_ex("b2b_a", 8'h11);
        present(8'h12); step(); expect_ex("b2b_b", 8'h12);
        present(8'h13); step(); expect_ex("b2b_c", 8'h13);
        idle_in(); step();
        expect_nop("b2b_drain");
        check("b2b_stall", stall_cnt, 0);
        check("b2b_bubble", bubble_cnt, 11);

        // Back-pressure: A in main, B in skid, C held by decode
        ex_ready = 1'b0;
        present(8'h31); step(); expect_ex("bp_a", 8'h31);
        present(8'h32); #1; check("bp_ready_b", id_ready, 1);
        step();
        present(8'h33); #1; check("bp_ready_c", id_ready, 0);
        step(); step();
        expect_ex("bp_hold", 8'h31);
        check("bp_ready_hold", id_ready, 0);
        ex_ready = 1'b1;
        step(); expect_ex("bp_out_b", 8'h32);
        step(); expect_ex("bp_out_c", 8'h33);
        idle_in(); step();
        expect_nop("bp_drain");
        check("bp_stall", stall_cnt, 3);

        // Flush while both entries are held; D must never issue
        ex_ready = 1'b0;
        present(8'h41); step();
        present(8'h42); step();
        present(8'h44); flush = 1'b1; #1;
        check("fl_ready_during", id_ready, 0);
        step();
        flush = 1'b0; idle_in(); #1;
        expect_nop("fl_after");
        check("fl_ready_after", id_ready, 1);
        check("fl_stall", stall_cnt, 5);
        ex_ready = 1'b1;
        step(); step();
        check("fl_no_d", ex_valid, 0);

        // Reset while in the skid state drops both entries
        ex_ready = 1'b0;
        present(8'h51); step();
        present(8'h52); step();
        idle_in(); rst = 1'b1; #1;
        check("rst2_ready_during", id_ready, 0);
        step();
        expect_nop("rst2");
        check("rst2_stall", stall_cnt, 0);
        check("rst2_bubble", bubble_cnt, 0);
        rst = 1'b0; #1;
        check("rst2_ready_after", id_ready, 1);

        // Saturation on the CNT_W=3 instance: 12 stalled cycles pin at 7
        present(8'h61); step();
        idle_in();
        for (int i = 0; i < 7; i++) step();
        check("sat3_at7", stall_cnt3, 7);
        for (int i = 0; i < 5; i++) step();
        check("sat3_hold", stall_cnt3, 7);
        check("sat16_cnt", stall_cnt, 12);
        check("sat3_bubble", bubble_cnt3, 1);
        check("sat3_ex", ex_aluop3, 8'h61);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
